jtag_tap_controller: RTL and testbench

IEEE 1149.1-style JTAG TAP controller for the RISC-V system top level. It runs the 16-state TAP FSM and owns the instruction register plus the IDCODE, USERCODE and BYPASS data registers. It exposes TAP state strobes and a debug-chain select so the advanced debug unit can attach its own data register. It sits between the chip JTAG pins and the debug controller.

---
 rtl/jtag_tap_pkg.sv | 55 +++++
 rtl/jtag_tap_if.sv | 39 +++
 rtl/jtag_tap_fsm.sv | 62 ++++++
 rtl/jtag_tap_controller.sv | 141 ++++++++++++++
 tb/tb_jtag_tap_controller.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtag_tap_pkg.sv
// Shared TAP types: 1149.1 state encoding, instruction opcodes and
// the data-register selection that an instruction decodes to.
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    TLR,
    RTI,
    SelDR,
    CapDR,
    ShDR,
    Ex1DR,
    PauDR,
    Ex2DR,
    UpdDR,
    SelIR,
    CapIR,
    ShIR,
    Ex1IR,
    PauIR,
    Ex2IR,
    UpdIR
  } tap_state_t;

  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_USERCODE,
    DR_DEBUG
  } dr_sel_t;

  localparam logic [3:0] OP_EXTEST         = 4'h0;
  localparam logic [3:0] OP_SAMPLE_PRELOAD = 4'h1;
  localparam logic [3:0] OP_IDCODE         = 4'h2;
  localparam logic [3:0] OP_USERCODE       = 4'h3;
  localparam logic [3:0] OP_DEBUG          = 4'h8;
  localparam logic [3:0] OP_BYPASS         = 4'hF;

  // Loaded into the IR shift register in Capture-IR; the fixed 01 in the
  // low bits lets a host detect a broken scan chain.
  localparam logic [3:0] IR_CAPTURE = 4'b0101;

  // There is no boundary-scan register, so EXTEST/SAMPLE_PRELOAD and
  // every unknown opcode fall through to the 1-bit bypass register.
  function automatic dr_sel_t decode_ir(input logic [3:0] ir, input logic usercode_en);
    dr_sel_t sel;
    case (ir)
      OP_IDCODE:   sel = DR_IDCODE;
      OP_USERCODE: sel = usercode_en ? DR_USERCODE : DR_BYPASS;
      OP_DEBUG:    sel = DR_DEBUG;
      default:     sel = DR_BYPASS;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/jtag_tap_if.sv
// Link between the TAP controller and the debug unit that owns the
// DEBUG data register: state strobes, chain select and serial data.
interface jtag_tap_if;

  logic tap_tck;
  logic tap_TestLogicReset;
  logic tap_CaptureDR;
  logic tap_ShiftDR;
  logic tap_PauseDR;
  logic tap_UpdateDR;
  logic dbg_sel;
  logic dbg_tdi;
  logic dbg_tdo;

  modport master (
    output tap_tck,
    output tap_TestLogicReset,
    output tap_CaptureDR,
    output tap_ShiftDR,
    output tap_PauseDR,
    output tap_UpdateDR,
    output dbg_sel,
    output dbg_tdi,
    input  dbg_tdo
  );

  modport slave (
    input  tap_tck,
    input  tap_TestLogicReset,
    input  tap_CaptureDR,
    input  tap_ShiftDR,
    input  tap_PauseDR,
    input  tap_UpdateDR,
    input  dbg_sel,
    input  dbg_tdi,
    output dbg_tdo
  );

endinterface

// File: rtl/jtag_tap_fsm.sv
// 16-state 1149.1 TAP state machine, advanced by TMS on every rising
// edge, with one-hot decodes of the states the registers care about.
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic clk,
  input  logic srst,
  input  logic i_tms,
  output logic o_tlr,
  output logic o_capture_dr,
  output logic o_shift_dr,
  output logic o_pause_dr,
  output logic o_update_dr,
  output logic o_capture_ir,
  output logic o_shift_ir,
  output logic o_update_ir
);

  tap_state_t r_state;
  tap_state_t w_state_next;

  always_ff @(posedge clk) begin
    if (srst) begin
      r_state <= TLR;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      TLR:     w_state_next = i_tms ? TLR   : RTI;
      RTI:     w_state_next = i_tms ? SelDR : RTI;
      SelDR:   w_state_next = i_tms ? SelIR : CapDR;
      CapDR:   w_state_next = i_tms ? Ex1DR : ShDR;
      ShDR:    w_state_next = i_tms ? Ex1DR : ShDR;
      Ex1DR:   w_state_next = i_tms ? UpdDR : PauDR;
      PauDR:   w_state_next = i_tms ? Ex2DR : PauDR;
      Ex2DR:   w_state_next = i_tms ? UpdDR : ShDR;
      UpdDR:   w_state_next = i_tms ? SelDR : RTI;
      SelIR:   w_state_next = i_tms ? TLR   : CapIR;
      CapIR:   w_state_next = i_tms ? Ex1IR : ShIR;
      ShIR:    w_state_next = i_tms ? Ex1IR : ShIR;
      Ex1IR:   w_state_next = i_tms ? UpdIR : PauIR;
      PauIR:   w_state_next = i_tms ? Ex2IR : PauIR;
      Ex2IR:   w_state_next = i_tms ? UpdIR : ShIR;
      UpdIR:   w_state_next = i_tms ? SelDR : RTI;
      default: w_state_next = TLR;
    endcase
  end

  assign o_tlr        = (r_state == TLR);
  assign o_capture_dr = (r_state == CapDR);
  assign o_shift_dr   = (r_state == ShDR);
  assign o_pause_dr   = (r_state == PauDR);
  assign o_update_dr  = (r_state == UpdDR);
  assign o_capture_ir = (r_state == CapIR);
  assign o_shift_ir   = (r_state == ShIR);
  assign o_update_ir  = (r_state == UpdIR);

endmodule

// File: rtl/jtag_tap_controller.sv
// JTAG TAP: IR, IDCODE/USERCODE/BYPASS data registers and the TDO mux.
// Define JTAG_USERCODE_EN to give the USERCODE opcode its own 32-bit register.
module jtag_tap_controller
  import jtag_tap_pkg::*;
#(
  parameter logic [31:0] JTAG_IDCODE   = 32'h0000_0001,
  parameter logic [31:0] JTAG_USERCODE = 32'h0000_0000,
  parameter int          IR_WIDTH      = 4
) (
  input  logic       jtag_tck,
  input  logic       jtag_trst,
  input  logic       jtag_tms,
  input  logic       jtag_tdi,
  output logic       jtag_tdo,
  output logic       jtag_tdo_oe,
  jtag_tap_if.master dbg_if
);

`ifdef JTAG_USERCODE_EN
  localparam logic USERCODE_EN = 1'b1;
`else
  localparam logic USERCODE_EN = 1'b0;
`endif

  logic w_tlr;
  logic w_capture_dr;
  logic w_shift_dr;
  logic w_pause_dr;
  logic w_update_dr;
  logic w_capture_ir;
  logic w_shift_ir;
  logic w_update_ir;

  logic [IR_WIDTH-1:0] r_ir;
  logic [IR_WIDTH-1:0] r_ir_shift;
  logic [IR_WIDTH-1:0] w_ir_shift_next;
  logic [31:0]         r_dr_shift;
  logic [31:0]         w_dr_shift_next;
  logic                r_bypass;
  dr_sel_t             w_dr_sel;

  jtag_tap_fsm u_fsm (
    .clk          (jtag_tck),
    .srst         (jtag_trst),
    .i_tms        (jtag_tms),
    .o_tlr        (w_tlr),
    .o_capture_dr (w_capture_dr),
    .o_shift_dr   (w_shift_dr),
    .o_pause_dr   (w_pause_dr),
    .o_update_dr  (w_update_dr),
    .o_capture_ir (w_capture_ir),
    .o_shift_ir   (w_shift_ir),
    .o_update_ir  (w_update_ir)
  );

  assign w_dr_sel = decode_ir(r_ir, USERCODE_EN);

  // Both shift registers move right with TDI entering at the MSB.
  genvar gi;
  for (gi = 0; gi < IR_WIDTH; gi++) begin : g_ir_shift
    if (gi == IR_WIDTH - 1) begin : g_msb
      assign w_ir_shift_next[gi] = jtag_tdi;
    end else begin : g_lsb
      assign w_ir_shift_next[gi] = r_ir_shift[gi+1];
    end
  end

  for (gi = 0; gi < 32; gi++) begin : g_dr_shift
    if (gi == 31) begin : g_msb
      assign w_dr_shift_next[gi] = jtag_tdi;
    end else begin : g_lsb
      assign w_dr_shift_next[gi] = r_dr_shift[gi+1];
    end
  end

  always_ff @(posedge jtag_tck) begin
    if (jtag_trst) begin
      r_ir       <= OP_IDCODE;
      r_ir_shift <= '0;
    end else begin
      if (w_tlr) begin
        r_ir <= OP_IDCODE;
      end else if (w_update_ir) begin
        r_ir <= r_ir_shift;
      end
      if (w_capture_ir) begin
        r_ir_shift <= IR_CAPTURE;
      end else if (w_shift_ir) begin
        r_ir_shift <= w_ir_shift_next;
      end
    end
  end

  // DEBUG owns no local register; the debug unit follows the strobes.
  always_ff @(posedge jtag_tck) begin
    if (jtag_trst) begin
      r_dr_shift <= '0;
      r_bypass   <= 1'b0;
    end else if (w_capture_dr) begin
      case (w_dr_sel)
        DR_IDCODE:   r_dr_shift <= JTAG_IDCODE;
        DR_USERCODE: r_dr_shift <= JTAG_USERCODE;
        DR_BYPASS:   r_bypass   <= 1'b0;
        default:     ;
      endcase
    end else if (w_shift_dr) begin
      case (w_dr_sel)
        DR_IDCODE,
        DR_USERCODE: r_dr_shift <= w_dr_shift_next;
        DR_BYPASS:   r_bypass   <= jtag_tdi;
        default:     ;
      endcase
    end
  end

  always_comb begin
    jtag_tdo = 1'b0;
    if (w_shift_ir) begin
      jtag_tdo = r_ir_shift[0];
    end else if (w_shift_dr) begin
      case (w_dr_sel)
        DR_IDCODE,
        DR_USERCODE: jtag_tdo = r_dr_shift[0];
        DR_DEBUG:    jtag_tdo = dbg_if.dbg_tdo;
        default:     jtag_tdo = r_bypass;
      endcase
    end
  end

  assign jtag_tdo_oe = w_shift_ir | w_shift_dr;

  assign dbg_if.tap_tck            = jtag_tck;
  assign dbg_if.tap_TestLogicReset = w_tlr;
  assign dbg_if.tap_CaptureDR      = w_capture_dr;
  assign dbg_if.tap_ShiftDR        = w_shift_dr;
  assign dbg_if.tap_PauseDR        = w_pause_dr;
  assign dbg_if.tap_UpdateDR       = w_update_dr;
  assign dbg_if.dbg_sel            = (r_ir == OP_DEBUG);
  assign dbg_if.dbg_tdi            = jtag_tdi;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Self-checking bench: FSM walk table plus IR/DR scan sequences, with
// expected TDO bits queued as stimulus is planned and popped as they appear.
module tb_jtag_tap_controller;
  import jtag_tap_pkg::*;

  localparam logic [31:0] IDC = 32'h1BA5_E0C3;
  localparam logic [31:0] UC  = 32'hCAFE_0001;

  logic tck  = 1'b0;
  logic trst = 1'b1;
  logic tms  = 1'b0;
  logic tdi  = 1'b0;
  logic tdo;
  logic tdo_oe;

  jtag_tap_if dbg_if ();

  jtag_tap_controller #(
    .JTAG_IDCODE   (IDC),
    .JTAG_USERCODE (UC),
    .IR_WIDTH      (4)
  ) dut (
    .jtag_tck    (tck),
    .jtag_trst   (trst),
    .jtag_tms    (tms),
    .jtag_tdi    (tdi),
    .jtag_tdo    (tdo),
    .jtag_tdo_oe (tdo_oe),
    .dbg_if      (dbg_if.master)
  );

  always #5 tck = ~tck;

  typedef struct {
    logic       tms;
    logic [5:0] exp;   // {tlr, capture_dr, shift_dr, pause_dr, update_dr, tdo_oe}
  } vec_t;

  vec_t       vecs[21];
  logic       exp_q[$];
  logic [5:0] exp_v_q[$];
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic check_tdo_q(input string name);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard empty, got %0b, want a queued bit", name, tdo);
    end else begin
      check(name, {31'd0, tdo}, {31'd0, exp_q.pop_front()});
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read there too.
  task automatic step(input logic t_tms, input logic t_tdi);
    tms = t_tms;
    tdi = t_tdi;
    @(posedge tck);
    #1;
  endtask

  task automatic goto_rti();
    repeat (5) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic goto_shdr();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // From RTI: scan op into the IR, checking the 0101 capture on TDO, back to RTI.
  task automatic load_ir(input logic [3:0] op);
    logic [3:0] cap;
    cap = IR_CAPTURE;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) exp_q.push_back(cap[i]);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ir%0h_oe%0d", op, i), {31'd0, tdo_oe}, 32'd1);
      check_tdo_q($sformatf("ir%0h_tdo%0d", op, i));
      step(i == 3, op[i]);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // In ShDR: shift n bits, comparing TDO with the queue, then go to RTI.
  task automatic shift_dr(input string name, input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_oe%0d", name, i), {31'd0, tdo_oe}, 32'd1);
      check_tdo_q($sformatf("%s_tdo%0d", name, i));
      step(i == n - 1, bits[i]);
    end
    check($sformatf("%s_oe_after", name), {31'd0, tdo_oe}, 32'd0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  function automatic logic [5:0] strobes();
    return {dbg_if.tap_TestLogicReset, dbg_if.tap_CaptureDR, dbg_if.tap_ShiftDR,
            dbg_if.tap_PauseDR, dbg_if.tap_UpdateDR, tdo_oe};
  endfunction

  initial begin
    logic [31:0] pat;
    logic [2:0]  dpat;
    logic [2:0]  tpat;

    vecs[0]  = '{1'b0, 6'b000000};  // RTI
    vecs[1]  = '{1'b1, 6'b000000};  // SelDR
    vecs[2]  = '{1'b0, 6'b010000};  // CapDR
    vecs[3]  = '{1'b0, 6'b001001};  // ShDR
    vecs[4]  = '{1'b1, 6'b000000};  // Ex1DR
    vecs[5]  = '{1'b0, 6'b000100};  // PauDR
    vecs[6]  = '{1'b1, 6'b000000};  // Ex2DR
    vecs[7]  = '{1'b0, 6'b001001};  // ShDR
    vecs[8]  = '{1'b1, 6'b000000};  // Ex1DR
    vecs[9]  = '{1'b1, 6'b000010};  // UpdDR
    vecs[10] = '{1'b1, 6'b000000};  // SelDR
    vecs[11] = '{1'b1, 6'b000000};  // SelIR
    vecs[12] = '{1'b0, 6'b000000};  // CapIR
    vecs[13] = '{1'b0, 6'b000001};  // ShIR
    vecs[14] = '{1'b1, 6'b000000};  // Ex1IR
    vecs[15] = '{1'b0, 6'b000000};  // PauIR
    vecs[16] = '{1'b1, 6'b000000};  // Ex2IR
    vecs[17] = '{1'b1, 6'b000000};  // UpdIR
    vecs[18] = '{1'b1, 6'b000000};  // SelDR
    vecs[19] = '{1'b1, 6'b000000};  // SelIR
    vecs[20] = '{1'b1, 6'b100000};  // TLR

    dbg_if.dbg_tdo = 1'b0;

    // Reset state
    trst = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("rst_tlr", {31'd0, dbg_if.tap_TestLogicReset}, 32'd1);
    check("rst_oe", {31'd0, tdo_oe}, 32'd0);
    check("rst_tdo", {31'd0, tdo}, 32'd0);
    check("rst_dbg_sel", {31'd0, dbg_if.dbg_sel}, 32'd0);
    check("tap_tck_hi", {31'd0, dbg_if.tap_tck}, {31'd0, tck});
    #5;
    check("tap_tck_lo", {31'd0, dbg_if.tap_tck}, {31'd0, tck});
    trst = 1'b0;

    // FSM walk through every state from TLR and back
    for (int i = 0; i < 21; i++) begin
      exp_v_q.push_back(vecs[i].exp);
      step(vecs[i].tms, 1'b0);
      check($sformatf("vec%0d", i), {26'd0, strobes()}, {26'd0, exp_v_q.pop_front()});
    end

    // IDCODE read after reset path, LSB first
    step(1'b0, 1'b0);
    goto_shdr();
    for (int i = 0; i < 32; i++) exp_q.push_back(IDC[i]);
    shift_dr("idcode", 32'd0, 32);

    // IR <- BYPASS, then 1-bit delay through bypass
    load_ir(OP_BYPASS);
    check("byp_dbg_sel", {31'd0, dbg_if.dbg_sel}, 32'd0);
    goto_shdr();
    pat = 32'h0000_000D;             // tdi 1,0,1,1
    exp_q.push_back(1'b0);
    for (int i = 1; i < 4; i++) exp_q.push_back(pat[i-1]);
    shift_dr("bypass", pat, 4);

    // Five TMS=1 edges from ShDR reach TLR and restore IR=IDCODE
    goto_shdr();
    check("sh_before_tlr", {26'd0, strobes()}, 32'b001001);
    repeat (5) step(1'b1, 1'b0);
    check("tms5_tlr", {31'd0, dbg_if.tap_TestLogicReset}, 32'd1);
    step(1'b0, 1'b0);
    goto_shdr();
    for (int i = 0; i < 8; i++) exp_q.push_back(IDC[i]);
    shift_dr("idcode_again", 32'd0, 8);

    // DEBUG: TDO follows dbg_tdo, dbg_tdi follows jtag_tdi, strobe order
    load_ir(OP_DEBUG);
    check("dbg_sel_set", {31'd0, dbg_if.dbg_sel}, 32'd1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("dbg_capture", {29'd0, dbg_if.tap_CaptureDR, dbg_if.tap_ShiftDR, dbg_if.tap_UpdateDR}, 32'b100);
    step(1'b0, 1'b0);
    check("dbg_shift", {29'd0, dbg_if.tap_CaptureDR, dbg_if.tap_ShiftDR, dbg_if.tap_UpdateDR}, 32'b010);
    dpat = 3'b101;
    tpat = 3'b110;
    for (int i = 0; i < 3; i++) begin
      dbg_if.dbg_tdo = dpat[i];
      tdi = tpat[i];
      #1;
      exp_q.push_back(dpat[i]);
      check_tdo_q($sformatf("dbg_tdo%0d", i));
      check($sformatf("dbg_tdi%0d", i), {31'd0, dbg_if.dbg_tdi}, {31'd0, tpat[i]});
      step(i == 2, tpat[i]);
    end
    dbg_if.dbg_tdo = 1'b0;
    step(1'b1, 1'b0);
    check("dbg_update", {29'd0, dbg_if.tap_CaptureDR, dbg_if.tap_ShiftDR, dbg_if.tap_UpdateDR}, 32'b001);
    step(1'b0, 1'b0);
    check("dbg_sel_held", {31'd0, dbg_if.dbg_sel}, 32'd1);

    // USERCODE: own register with the feature, bypass without it
    load_ir(OP_USERCODE);
    check("uc_dbg_sel", {31'd0, dbg_if.dbg_sel}, 32'd0);
    goto_shdr();
`ifdef JTAG_USERCODE_EN
    for (int i = 0; i < 32; i++) exp_q.push_back(UC[i]);
    shift_dr("usercode", 32'd0, 32);
`else
    pat = 32'h0F0F_3355;
    exp_q.push_back(1'b0);
    for (int i = 1; i < 32; i++) exp_q.push_back(pat[i-1]);
    shift_dr("usercode_byp", pat, 32);
`endif

    // Reset in the middle of an IR shift aborts it
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("midir_oe", {31'd0, tdo_oe}, 32'd1);
    trst = 1'b1;
    step(1'b0, 1'b0);
    check("midir_rst_tlr", {31'd0, dbg_if.tap_TestLogicReset}, 32'd1);
    check("midir_rst_oe", {31'd0, tdo_oe}, 32'd0);
    step(1'b0, 1'b0);
    check("rst_beats_tms", {31'd0, dbg_if.tap_TestLogicReset}, 32'd1);
    trst = 1'b0;
    step(1'b0, 1'b0);
    check("midir_rti", {26'd0, strobes()}, 32'd0);
    goto_shdr();
    for (int i = 0; i < 32; i++) exp_q.push_back(IDC[i]);
    shift_dr("idcode_post_rst", 32'd0, 32);

    goto_rti();
    check("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
